pong_game_ctrl: RTL

- Game-level sequencer inside pong_top, one clock domain with the VGA/physics logic.
- Once per video frame it launches the ball/paddle physics update through a req/done handshake.
- It interprets miss results from that update, keeps both scores, enforces a serve delay, declares game over and drives the board LED.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_serve_timer.sv | 41 ++++
 rtl/pong_game_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared state encoding, serve-direction encoding and default game constants
// for the pong game sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    UPDATE    = 3'd3,
    POINT     = 3'd4,
    GAME_OVER = 3'd5
  } game_state_t;

  // serve_dir encoding: 0 sends the ball toward the right player
  localparam logic SERVE_R = 1'b0;
  localparam logic SERVE_L = 1'b1;

  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_SCORE_W      = 4;

endpackage

// File: rtl/pong_serve_timer.sv
// Loadable down-counter of frame ticks; last_o flags the final tick of the
// serve hold so the sequencer can leave SERVE on that tick.
module pong_serve_timer import pong_pkg::*; #(
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic tick_i,
  output logic last_o
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // next count: reload wins over a tick; the counter parks at zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CW'(SERVE_FRAMES);
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // counter register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CW'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level sequencer: launches one physics update per frame, scores misses,
// holds the ball during serve, and declares game over.
module pong_game_ctrl import pong_pkg::*; #(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int SCORE_W      = DEF_SCORE_W
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic               update_done,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               update_req,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               overrun,
  output logic               LED
);

  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);

  game_state_t        state_q, state_d;
  logic               update_req_q, update_req_d;
  logic               ball_reset_q, ball_reset_d;
  logic               serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               overrun_q, overrun_d;
  logic               game_over_q;
  logic               timer_load_s, timer_tick_s, timer_last_s, win_s, abort_s;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v >= WIN_V) ? v : v + SCORE_W'(1);
  endfunction

  assign win_s        = (score_l_q == WIN_V) || (score_r_q == WIN_V);
  assign abort_s      = (state_q != IDLE) && !enable;
  assign timer_tick_s = (state_q == SERVE) && frame_tick;

  pong_serve_timer #(.SERVE_FRAMES(SERVE_FRAMES)) u_serve_timer (
    .clk_i   (CLK100MHZ),
    .reset_i (reset),
    .load_i  (timer_load_s),
    .tick_i  (timer_tick_s),
    .last_o  (timer_last_s)
  );

  // state and datapath registers
  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      state_q      <= IDLE;
      update_req_q <= 1'b0;
      ball_reset_q <= 1'b0;
      serve_dir_q  <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      overrun_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      update_req_q <= update_req_d;
      ball_reset_q <= ball_reset_d;
      serve_dir_q  <= serve_dir_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      overrun_q    <= overrun_d;
      game_over_q  <= (state_d == GAME_OVER);
    end
  end

  // next-state logic; dropping enable aborts from any active state
  always_comb begin
    state_d = state_q;
    if (abort_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = enable ? SERVE : IDLE;
        SERVE:     state_d = (frame_tick && timer_last_s) ? PLAY : SERVE;
        PLAY:      state_d = frame_tick ? UPDATE : PLAY;
        UPDATE: begin
          if (update_done) begin
            state_d = (miss_l || miss_r) ? POINT : PLAY;
          end else begin
            state_d = UPDATE;
          end
        end
        POINT:     state_d = win_s ? GAME_OVER : SERVE;
        GAME_OVER: state_d = GAME_OVER;
        default:   state_d = IDLE;
      endcase
    end
  end

  // output / datapath next values; a tick during an outstanding update is dropped but flagged
  always_comb begin
    update_req_d = 1'b0;
    ball_reset_d = 1'b0;
    serve_dir_d  = serve_dir_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    overrun_d    = overrun_q;
    timer_load_s = 1'b0;
    if (abort_s) begin
      update_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            score_l_d    = '0;
            score_r_d    = '0;
            overrun_d    = 1'b0;
            ball_reset_d = 1'b1;
            timer_load_s = 1'b1;
          end else begin
            ball_reset_d = 1'b0;
          end
        end
        PLAY:   update_req_d = frame_tick;
        UPDATE: begin
          overrun_d = overrun_q | frame_tick;
          if (update_done) begin
            update_req_d = 1'b0;
            if (miss_l && !miss_r) begin
              score_r_d   = sat_inc(score_r_q);
              serve_dir_d = SERVE_L;
            end else if (miss_r && !miss_l) begin
              score_l_d   = sat_inc(score_l_q);
              serve_dir_d = SERVE_R;
            end else begin
              serve_dir_d = serve_dir_q;
            end
          end else begin
            update_req_d = 1'b1;
          end
        end
        POINT: begin
          if (!win_s) begin
            ball_reset_d = 1'b1;
            timer_load_s = 1'b1;
          end else begin
            ball_reset_d = 1'b0;
          end
        end
        SERVE, GAME_OVER: update_req_d = 1'b0;
        default:          update_req_d = 1'b0;
      endcase
    end
  end

  assign update_req = update_req_q;
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign overrun    = overrun_q;
  assign game_over  = game_over_q;
  assign LED        = game_over_q;

endmodule
